keypad_scanner: RTL

- Input-side counterpart to the multiplexed 7-segment display driver: scans a 4x4 hex keypad (Pmod KYPD style) and decodes the pressed key back to a 4-bit hex value.
- Column multiplexing, row sampling, frame decoding, press/release debounce, and a single-cycle key event with a held code.
- Sits between the board keypad pins and the ALU operand/control registers, replacing slide-switch operand entry.

---
 rtl/keypad_pkg.sv | 11 +
 rtl/keypad_col_scan.sv | 56 +++++
 rtl/keypad_scanner.sv | 97 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared encodings and key map for the 4x4 hex keypad scanner.
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_e;
    typedef enum logic [1:0] {KIND_NONE, KIND_ONE, KIND_MULTI} kind_e;
    localparam logic [3:0] COL_RST = 4'b1110;
    // Nibble at index {row, col}: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: row synchronizer, column dwell/rotation and per-frame key classification.
module keypad_col_scan import keypad_pkg::*; #(
    parameter int SCAN_COUNT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       frame_done,
    output logic [1:0] frame_kind,
    output logic [3:0] frame_code
);
    localparam int CW = $clog2(SCAN_COUNT);
    logic [3:0] sync1_q, sync2_q, col_q, col_d, acc_code_q, acc_code_d, low, base_code;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] acc_n_q, acc_n_d, base_n, row_idx, col_idx;
    logic [2:0] zeros, total;
    logic last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 4'hf;
            sync2_q    <= 4'hf;
            cnt_q      <= '0;
            col_q      <= COL_RST;
            acc_n_q    <= '0;
            acc_code_q <= '0;
        end else begin
            sync1_q    <= row;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            acc_n_q    <= acc_n_d;
            acc_code_q <= acc_code_d;
        end
    end
    // Low-bit count saturates at 2: only none / one / many matters for a frame
    always_comb begin
        last       = cnt_q == CW'(SCAN_COUNT - 1);
        cnt_d      = last ? '0 : cnt_q + 1'b1;
        col_d      = last ? {col_q[2:0], col_q[3]} : col_q;
        low        = ~sync2_q;
        zeros      = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        row_idx    = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
        col_idx    = !col_q[0] ? 2'd0 : !col_q[1] ? 2'd1 : !col_q[2] ? 2'd2 : 2'd3;
        base_n     = col_q == COL_RST ? 2'd0 : acc_n_q;
        base_code  = col_q == COL_RST ? 4'd0 : acc_code_q;
        total      = {1'b0, base_n} + zeros;
        acc_n_d    = !last ? acc_n_q : total > 3'd1 ? 2'd2 : total[1:0];
        acc_code_d = !last ? acc_code_q :
                     (base_n == 2'd0 && zeros == 3'd1) ? key_map(row_idx, col_idx) : base_code;
        frame_done = last && col_q == 4'b0111;
        frame_kind = acc_n_d == 2'd0 ? KIND_NONE : acc_n_d == 2'd1 ? KIND_ONE : KIND_MULTI;
        frame_code = acc_code_d;
    end
    assign col = col_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad and reports debounced key presses.
module keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_COUNT     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_DOWN
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    state_e state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d, key_code_q, key_code_d, frame_code;
    logic [1:0] frame_kind;
    logic key_valid_q, key_valid_d, key_down_q, key_down_d;
    logic frame_done, one, none, same, final_cnt, press_ok, release_ok;
    keypad_col_scan #(.SCAN_COUNT(SCAN_COUNT)) u_scan (
        .clk        (CLK),
        .rst_n      (RST_N),
        .row        (ROW),
        .col        (COL),
        .frame_done (frame_done),
        .frame_kind (frame_kind),
        .frame_code (frame_code)
    );
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end
    always_comb begin
        one       = frame_kind == KIND_ONE;
        none      = frame_kind == KIND_NONE;
        same      = one && frame_code == cand_q;
        final_cnt = cnt_q == DW'(DEBOUNCE_SCANS - 1);
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        if (frame_done) begin
            case (state_q)
                IDLE: if (one) begin
                    state_d = DEB_PRESS;
                    cand_d  = frame_code;
                    cnt_d   = DW'(1);
                end
                DEB_PRESS: if (same) begin
                    state_d = final_cnt ? PRESSED : DEB_PRESS;
                    cnt_d   = final_cnt ? '0 : cnt_q + 1'b1;
                end else if (one) begin
                    cand_d = frame_code;
                    cnt_d  = DW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                PRESSED: if (none) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = DW'(1);
                end
                DEB_RELEASE: if (none) begin
                    state_d = final_cnt ? IDLE : DEB_RELEASE;
                    cnt_d   = final_cnt ? '0 : cnt_q + 1'b1;
                end else begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_comb begin
        press_ok    = frame_done && state_q == DEB_PRESS && same && final_cnt;
        release_ok  = frame_done && state_q == DEB_RELEASE && none && final_cnt;
        key_valid_d = press_ok;
        key_code_d  = press_ok ? cand_q : key_code_q;
        key_down_d  = press_ok ? 1'b1 : release_ok ? 1'b0 : key_down_q;
    end
    assign KEY_CODE  = key_code_q;
    assign KEY_VALID = key_valid_q;
    assign KEY_DOWN  = key_down_q;
endmodule
